// File: rtl/spi_master_if.sv
// rtl/spi_master_if.sv - host handshake and SPI pin bundle for spi_master
interface spi_master_if #(
    parameter int PACKET_WIDTH = 40
);
    logic [PACKET_WIDTH-1:0] txData;
    logic                    start;
    logic                    busy;
    logic [PACKET_WIDTH-1:0] rxData;
    logic                    dataReady;
    logic                    spi_SCLK;
    logic                    spi_SSEL;
    logic                    spi_MOSI;
    logic                    spi_MISO;

    modport master (
        input  txData,
        input  start,
        input  spi_MISO,
        output busy,
        output rxData,
        output dataReady,
        output spi_SCLK,
        output spi_SSEL,
        output spi_MOSI
    );

    modport slave (
        output txData,
        output start,
        output spi_MISO,
        input  busy,
        input  rxData,
        input  dataReady,
        input  spi_SCLK,
        input  spi_SSEL,
        input  spi_MOSI
    );
endinterface

// File: rtl/spi_master.sv
// rtl/spi_master.sv - SPI mode-0 master with lead/trail/gap framing
// Optional 2-flop MISO synchronizer enabled by SPI_MASTER_MISO_SYNC_EN.
`ifdef SPI_MASTER_MISO_SYNC_EN
module synchronizer (
    input  logic clk,
    input  logic reset,
    input  logic d,
    output logic q
);
    logic meta_q, meta_d;
    logic sync_q, sync_d;

    always_comb begin
        meta_d = d;
        sync_d = meta_q;
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= meta_d;
            sync_q <= sync_d;
        end
    end

    assign q = sync_q;
endmodule
`endif

module spi_master #(
    parameter int PACKET_WIDTH = 40,
    parameter int CLK_DIV      = 4
) (
    input logic          clk,
    input logic          reset,
    spi_master_if.master bus
);
    localparam int DIV_W = $clog2(CLK_DIV);
    localparam int BIT_W = $clog2(PACKET_WIDTH);
    localparam logic [DIV_W-1:0] DIV_LAST  = DIV_W'(CLK_DIV - 1);
    localparam logic [BIT_W-1:0] BITS_LAST = BIT_W'(PACKET_WIDTH - 1);

    typedef enum logic [2:0] {IDLE, LEAD, HIGH, LOW, TRAIL, GAP} state_t;

    state_t                  state_q, state_d;
    logic [DIV_W-1:0]        div_q, div_d;
    logic [BIT_W-1:0]        bits_q, bits_d;
    logic [PACKET_WIDTH-1:0] tx_q, tx_d;
    logic [PACKET_WIDTH-1:0] rx_shift_q, rx_shift_d;
    logic [PACKET_WIDTH-1:0] rx_data_q, rx_data_d;
    logic                    sclk_q, sclk_d;
    logic                    ssel_q, ssel_d;
    logic                    busy_q, busy_d;
    logic                    ready_q, ready_d;
    logic                    miso_s;
    logic                    div_done;

`ifdef SPI_MASTER_MISO_SYNC_EN
    synchronizer u_miso_sync (
        .clk   (clk),
        .reset (reset),
        .d     (bus.spi_MISO),
        .q     (miso_s)
    );
`else
    assign miso_s = bus.spi_MISO;
`endif

    assign div_done = (div_q == DIV_LAST);

    // MOSI is the MSB of the TX shifter; clearing the shifter at TRAIL exit idles MOSI low.
    always_comb begin
        state_d    = state_q;
        div_d      = div_q;
        bits_d     = bits_q;
        tx_d       = tx_q;
        rx_shift_d = rx_shift_q;
        rx_data_d  = rx_data_q;
        sclk_d     = sclk_q;
        ssel_d     = ssel_q;
        busy_d     = busy_q;
        ready_d    = 1'b0;

        if (state_q != IDLE) begin
            div_d = div_done ? '0 : div_q + DIV_W'(1);
        end

        case (state_q)
            IDLE: begin
                if (bus.start) begin
                    state_d = LEAD;
                    div_d   = '0;
                    bits_d  = BITS_LAST;
                    tx_d    = bus.txData;
                    ssel_d  = 1'b0;
                    busy_d  = 1'b1;
                end
            end
            LEAD, LOW: begin
                if (div_done) begin
                    state_d = HIGH;
                    sclk_d  = 1'b1;
                end
            end
            HIGH: begin
                if (div_done) begin
                    rx_shift_d = {rx_shift_q[PACKET_WIDTH-2:0], miso_s};
                    sclk_d     = 1'b0;
                    if (bits_q == '0) begin
                        state_d = TRAIL;
                    end else begin
                        state_d = LOW;
                        bits_d  = bits_q - BIT_W'(1);
                        tx_d    = tx_q << 1;
                    end
                end
            end
            TRAIL: begin
                if (div_done) begin
                    state_d   = GAP;
                    ssel_d    = 1'b1;
                    tx_d      = '0;
                    rx_data_d = rx_shift_q;
                    ready_d   = 1'b1;
                end
            end
            GAP: begin
                if (div_done) begin
                    state_d = IDLE;
                    busy_d  = 1'b0;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state_q    <= IDLE;
            div_q      <= '0;
            bits_q     <= '0;
            tx_q       <= '0;
            rx_shift_q <= '0;
            rx_data_q  <= '0;
            sclk_q     <= 1'b0;
            ssel_q     <= 1'b1;
            busy_q     <= 1'b0;
            ready_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            div_q      <= div_d;
            bits_q     <= bits_d;
            tx_q       <= tx_d;
            rx_shift_q <= rx_shift_d;
            rx_data_q  <= rx_data_d;
            sclk_q     <= sclk_d;
            ssel_q     <= ssel_d;
            busy_q     <= busy_d;
            ready_q    <= ready_d;
        end
    end

    assign bus.spi_SCLK  = sclk_q;
    assign bus.spi_SSEL  = ssel_q;
    assign bus.spi_MOSI  = tx_q[PACKET_WIDTH-1];
    assign bus.busy      = busy_q;
    assign bus.rxData    = rx_data_q;
    assign bus.dataReady = ready_q;
endmodule

// File: doc/spi_master.md
# spi_master

Master (initiator) end of the board SPI link, the counterpart to the FPGA-side `spi_serdes` slave. It shifts one `PACKET_WIDTH`-bit word out on MOSI while shifting one word in from MISO. It generates SCLK, SSEL, lead, trail and inter-packet gap timing from the system clock. It is used to drive on-board SPI peripherals and as the bench-side partner for slave verification.

## Interface
- `PACKET_WIDTH`, default 40: bits per transaction. Must be ≥ 2.
- `CLK_DIV`, default 4: length of each SCLK half-period, in `clk` cycles. Must be ≥ 4 so that a slave using 2-flop synchronizers sees every edge.
- `clk` input, 1 bit: system clock. Every flop is clocked on its rising edge.
- `reset` input, 1 bit: synchronous, active-high reset.
- `txData` input, `PACKET_WIDTH` bits: word to send, MSB first. Sampled only when a start is accepted.
- `start` input, 1 bit: request a transaction. Accepted on an edge where `start && !busy`.
- `busy` output, 1 bit: high from the accept edge until the inter-packet gap ends.
- `rxData` output, `PACKET_WIDTH` bits: last received word. Updated only on the `dataReady` edge.
- `dataReady` output, 1 bit: single-cycle pulse marking that `rxData` is valid.
- `spi_SCLK` output, 1 bit: SPI clock. Idles low.
- `spi_SSEL` output, 1 bit: slave select, active low. Idles high.
- `spi_MOSI` output, 1 bit: master data out.
- `spi_MISO` input, 1 bit: slave data in. Asynchronous to `clk`.

## Operation
- SPI mode 0 (CPOL=0, CPHA=0):
  - The slave samples MOSI on SCLK rise.
  - The master changes MOSI on SCLK fall.
  - The slave changes MISO on SCLK fall.
  - The master samples MISO on the final `clk` cycle of each SCLK-high phase. MISO has been stable for several cycles by then.
- The FSM has six states: IDLE, LEAD, HIGH, LOW, TRAIL, GAP. A divider counter `div` counts 0..CLK_DIV-1 in each non-IDLE state. A bit counter tracks bits remaining.
- IDLE → LEAD when a start is accepted. On that edge:
  - load the TX shift register from `txData`;
  - drive `spi_MOSI` = `txData[PACKET_WIDTH-1]`;
  - drive `spi_SSEL` = 0;
  - set `busy` = 1.
- LEAD → HIGH after CLK_DIV cycles; `spi_SCLK` goes to 1.
- At HIGH exit, shift the sampled MISO into the RX shift register LSB. Then:
  - if bits remain, go to LOW: `spi_SCLK` = 0, shift TX left, MOSI takes the next bit;
  - after the last bit, go to TRAIL: `spi_SCLK` = 0, MOSI holds.
- LOW → HIGH after CLK_DIV cycles.
- TRAIL → GAP after CLK_DIV cycles. On that edge:
  - `spi_SSEL` = 1, `spi_MOSI` = 0;
  - `rxData` takes the RX shift register;
  - `dataReady` = 1 for exactly one cycle.
- GAP → IDLE after CLK_DIV cycles; `busy` = 0.
- The inter-packet gap guarantees the slave's SSEL-driven reset completes.
- `start` is ignored while `busy` is high; there is no queueing. If `start` is held high, the next transaction is accepted on the first edge after `busy` falls.
- Reset values: `spi_SSEL` = 1, `spi_SCLK` = 0, `spi_MOSI` = 0, `busy` = 0, `dataReady` = 0, `rxData` = 0, state = IDLE.
- Reset mid-transaction: on the next edge, all outputs return to their reset values. No `dataReady` pulse is produced and the partial RX word is discarded.
- Reset asserted together with `start`: reset wins.

## Timing
- Let edge 0 be the accept edge. All outputs are registered; there is no combinational path from input to output.
- Bit k, for k = 0..PACKET_WIDTH-1 and counted MSB first:
  - SCLK rises at edge CLK_DIV·(2k+1);
  - SCLK falls at edge CLK_DIV·(2k+2).
- SSEL leads the first SCLK rise by CLK_DIV cycles and trails the last SCLK fall by CLK_DIV cycles.
- `dataReady` pulses and SSEL rises at edge CLK_DIV·(2·PACKET_WIDTH+1).
- `busy` falls at edge CLK_DIV·(2·PACKET_WIDTH+2). The earliest next accept is the edge after that.
- MOSI bit k is valid from edge CLK_DIV·2k (edge 0 for k=0) until SCLK falls for bit k.
- The MISO capture for bit k uses the synchronized value present at edge CLK_DIV·(2k+2).

## Configuration
- `SPI_MASTER_MISO_SYNC_EN` defined: `spi_MISO` passes through a 2-flop `synchronizer` before sampling, adding 2 cycles of latency. The sample point is unchanged, and CLK_DIV ≥ 4 keeps it correct.
- Undefined: `spi_MISO` is sampled directly with no synchronizer. This is for same-clock simulation and for MISO that is already synchronous.

## Test plan
- Reset values: assert `reset` for 3 cycles → SSEL=1, SCLK=0, MOSI=0, busy=0, dataReady=0, rxData=0.
- Loopback (PACKET_WIDTH=8, CLK_DIV=4), MOSI tied to MISO, `txData`=0xA5, start pulse:
  - `dataReady` pulses at edge 68 with `rxData`=0xA5;
  - `busy` falls at edge 72.
- Waveform check on the same run:
  - exactly 8 SCLK rises;
  - each high and low phase is 4 cycles;
  - SSEL is low 4 cycles before the first rise and 4 cycles after the last fall;
  - MOSI reads 1,0,1,0,0,1,0,1 at the rises.
- Against the `spi_serdes` slave (PACKET_WIDTH=40, CLK_DIV=4), both built with the macro defined:
  - slave loaded with 0x123456789A, master sends 0xDEADBEEF01;
  - required: master `rxData`=0x123456789A, slave `rxShiftReg`=0xDEADBEEF01, and the slave's `dataReady` pulses once.
- Hold `start` high with `txData` changing each cycle:
  - the second transaction begins the edge after `busy` falls;
  - the value of `txData` on that edge is the word sent;
  - `start` pulses during `busy` have no effect.
- Reset mid-transaction: assert `reset` during bit 3 → SSEL=1 and SCLK=0 on the next edge, and there is no `dataReady`. A following 0x3C loopback returns `rxData`=0x3C.
